wide_add_seq: RTL and testbench
===============================

Name: wide_add_seq

Overview:
- Multi-cycle wide adder that splits WIDTH-bit operands into 16-bit slices.
- Each cycle it feeds one slice into a single 16-bit carry-lookahead slice adder and registers the slice carry-out as the next slice's carry-in.
- Sits around the 16-bit CLA stage: it supplies the operand slices upstream and collects sum and carry downstream.
- Trades latency for area when adding 32/64/128-bit values on FPGA.

Parameters:
- WIDTH, 64, operand and sum width; must be a multiple of 16 and at least 32 (elaboration-time assertion).
- NSLICE, WIDTH/16, derived localparam giving the slice count; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to slice 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  registered sum.
- cout  out  1  carry-out of the top slice.
- ovf  out  1  signed overflow.
- op_sub  in  1  subtract select; present only with WIDE_ADD_SUB_EN.

Behaviour:
- Clock and reset (decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, slice index=0, carry register=0, operand registers=0.
- FSM states: IDLE, RUN, DONE.
- in_ready is 1 exactly when state is IDLE.
- IDLE: on in_valid && in_ready:
  - latch a, b and cin (the effective operands, see Optional Feature);
  - set index=0 and carry=cin;
  - go to RUN.
- RUN: each cycle:
  - sum[16*idx +: 16] <= slice sum of A_reg and B_reg slices with carry;
  - carry <= slice Cout;
  - idx++;
  - when idx==NSLICE-1, go to DONE at that edge.
- DONE, on entry:
  - out_valid=1;
  - cout = final carry;
  - ovf = (A_reg[MSB]==B_reg[MSB]) && (sum[MSB]!=A_reg[MSB]), using effective B.
- DONE, on out_valid && out_ready: out_valid<=0 and go to IDLE. The next input is accepted no earlier than the following cycle (no same-cycle turnaround).
- Latency: out_valid rises NSLICE cycles after the accept edge. Minimum initiation interval is NSLICE+2 cycles.
- Stability: sum, cout and ovf hold stable while out_valid=1 and out_ready=0, for any duration.
- in_valid while not IDLE is ignored; operands are not captured.
- Sum slices not yet written during RUN hold their previous value. Only DONE output is architecturally valid.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse is produced.
- Arithmetic is modulo 2^WIDTH. cout carries the WIDTH+1 bit.

Optional Feature:
- Macro WIDE_ADD_SUB_EN.
- Defined:
  - op_sub port exists and is latched with the operands;
  - when op_sub=1, effective B = ~b and effective carry-in = 1 (cin ignored);
  - cout=1 means no borrow;
  - ovf uses effective B.
- Undefined: no op_sub port; always addition with the cin port.

Decomposition:
- Package wide_add_pkg holds:
  - localparam SLICE_W=16;
  - typedef enum logic [1:0] {IDLE, RUN, DONE} wide_add_state_t;
  - function slice_count(width).
- One sub-module: CLA16, instantiated exactly once as the slice adder. Its Pout and Gout are left unconnected.

Test Plan:
- WIDTH=64, a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0, cout=1, ovf=0, out_valid exactly 4 cycles after accept.
- a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- a=0x0000_0000_FFFF_FFFF, b=0, cin=1 -> sum=0x0000_0001_0000_0000, cout=0 (carry crosses slices 0->1->2).
- Back-pressure: hold out_ready=0 for 6 cycles after out_valid, and pulse in_valid with new operands -> sum/cout/ovf unchanged, in_ready=0, second operands not captured. After out_ready=1, out_valid drops next edge, then in_ready=1.
- Reset asserted during RUN at idx=2 -> out_valid=0, sum=0, in_ready=1 immediately; the next transaction a=3, b=4 yields sum=7.
- WIDE_ADD_SUB_EN defined, a=5, b=7, op_sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. With a=7, b=5 -> sum=2, cout=1.

Source files
------------

// File: rtl/wide_add_pkg.sv
// Shared definitions for the sequential wide adder.
//   SLICE_W           width of one adder slice
//   wide_add_state_t  controller states
//   slice_count()     number of slices for a given operand width
package wide_add_pkg;

  localparam int unsigned SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wide_add_state_t;

  function automatic int unsigned slice_count(input int unsigned width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/wide_add_seq_cla16.sv
// CLA16: 16-bit two-level carry-lookahead adder slice.
//   A, B  16-bit operands        Cin   carry-in
//   S     16-bit sum             Cout  carry-out
//   Pout  group propagate        Gout  group generate
module CLA16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout,
  output logic        Pout,
  output logic        Gout
);

  always_comb begin : cla
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    g = A & B;
    p = A ^ B;

    // Per-nibble group generate/propagate
    for (int unsigned k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end

    // Second-level lookahead across nibbles
    gc[0] = Cin;
    gc[1] = gg[0] | (gp[0] & Cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & Cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & Cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & Cin);

    // Bit carries inside each nibble from its group carry-in
    c = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k]   | (p[4*k]   & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & c[4*k+1]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & c[4*k+2]);
    end

    S    = p ^ c;
    Cout = gc[4];
    Pout = &gp;
    Gout = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
         | (gp[3] & gp[2] & gp[1] & gg[0]);
  end

endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-cycle WIDTH-bit adder built around one 16-bit CLA
// slice, processing one slice per clock from LSB to MSB.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (ready only when idle)
//   a, b, cin            operands and carry-in
//   out_valid/out_ready  result handshake
//   sum, cout, ovf       registered sum, carry-out, signed overflow
//   op_sub               subtract select (only with WIDE_ADD_SUB_EN)
// Optional feature macro: WIDE_ADD_SUB_EN (adds op_sub, a - b = a + ~b + 1).
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
`ifdef WIDE_ADD_SUB_EN
  ,
  input  logic             op_sub
`endif
);

  localparam int unsigned NSLICE = slice_count(WIDTH);
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < 32) begin : g_width_chk
    $error("wide_add_seq: WIDTH must be a multiple of 16 and at least 32");
  end

  wide_add_state_t state_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid_q;

  // Effective operands: subtraction is folded in at capture time so the
  // slice datapath only ever adds.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
`ifdef WIDE_ADD_SUB_EN
  assign b_eff   = op_sub ? ~b : b;
  assign cin_eff = op_sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];

  CLA16 u_cla (
    .A    (slice_a),
    .B    (slice_b),
    .Cin  (carry_q),
    .S    (slice_sum),
    .Cout (slice_cout),
    .Pout (),
    .Gout ()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_eff;
            carry_q <= cin_eff;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
          carry_q <= slice_cout;
          if (idx_q == LAST_IDX) begin
            // The top slice sum is being written this edge, so overflow
            // uses its MSB directly rather than the not-yet-updated sum_q.
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            cout_q      <= slice_cout;
            ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                           (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
module tb_wide_add_seq;

  localparam int unsigned W  = 64;
  localparam int unsigned NS = W / 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         op_sub = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wide_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
`ifdef WIDE_ADD_SUB_EN
    ,
    .op_sub    (op_sub)
`endif
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on extended integers. Returns {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rc, input logic rsub);
    logic [W-1:0]        eb;
    logic                ec;
    logic [W:0]          full;
    logic signed [W+1:0] sr;
    logic signed [W+1:0] smax;
    logic signed [W+1:0] smin;
    logic                o;
    eb   = rsub ? ~rb : rb;
    ec   = rsub ? 1'b1 : rc;
    full = {1'b0, ra} + {1'b0, eb} + {{W{1'b0}}, ec};
    sr   = $signed({{2{ra[W-1]}}, ra}) + $signed({{2{eb[W-1]}}, eb})
         + $signed({{(W+1){1'b0}}, ec});
    smax = {3'b000, {(W-1){1'b1}}};
    smin = {3'b111, {(W-1){1'b0}}};
    o    = (sr > smax) || (sr < smin);
    return {o, full[W], full[W-1:0]};
  endfunction

  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input logic tsub, input int hold);
    logic [W+1:0] exp;
    int lat;
    exp = ref_add(ta, tb, tc, tsub);
    check_eq("in_ready_idle", in_ready, 1);
    a = ta; b = tb; cin = tc; op_sub = tsub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check_eq("latency", lat, NS);
    check_eq("sum", sum, exp[W-1:0]);
    check_eq("cout", cout, exp[W]);
    check_eq("ovf", ovf, exp[W+1]);
    for (int i = 0; i < hold; i++) begin
      // New operands offered while busy must be ignored.
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      tick();
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_ready", in_ready, 0);
      check_eq("hold_sum", {ovf, cout, sum}, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("drop_valid", out_valid, 0);
    check_eq("back_idle", in_ready, 1);
    check_eq("sum_after", sum, exp[W-1:0]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_sum", {ovf, cout, sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed vectors
    run_txn({W{1'b1}}, 64'd1, 1'b0, 1'b0, 0);
    run_txn(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
    run_txn(64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 0);
    run_txn(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 0);
    // Back-pressure with busy-time operand offers
    run_txn(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 6);

    // Reset in the middle of RUN (idx=2, low slices already written)
    a = 64'h0000_0000_FFFF_FFFF; b = '0; cin = 1'b1; op_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_sum", sum, 0);
    check_eq("midrst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_txn(64'd3, 64'd4, 1'b0, 1'b0, 0);

`ifdef WIDE_ADD_SUB_EN
    run_txn(64'd5, 64'd7, 1'b0, 1'b1, 0);
    run_txn(64'd7, 64'd5, 1'b0, 1'b1, 1);
`endif

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) ra = {W{1'b1}};
      if ($urandom_range(0, 4) == 0) rb[31:0] = 32'hFFFF_FFFF;
`ifdef WIDE_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_txn(ra, rb, 1'($urandom), rs, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
